// File: rtl/button_event_sched.sv
// Turns debounced button levels into press/release/long(/repeat) events, serialised round-robin onto one valid/ready port.
// Optional auto-repeat after a long press is enabled by defining BUTTON_EVENT_AUTOREPEAT_EN.
module button_event_sched #(
    parameter int WIDTH        = 4,
    parameter int CDIV         = 50_000,
    parameter int LONG_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    localparam int IDW         = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] lvl,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDW-1:0]   ev_id,
    output logic [1:0]       ev_type,
    output logic             ev_drop
);

    localparam int PW = (CDIV > 1) ? $clog2(CDIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CDIV - 1);
    localparam logic [15:0]   LONG_T  = 16'(LONG_TICKS);
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
    localparam logic [15:0]   REP_T   = 16'(REPEAT_TICKS);
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_LONG = 2'd2;

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_LONG    = 2'd2;
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
    localparam logic [1:0] EV_REPEAT  = 2'd3;
`endif

    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] r_lvl_q;
    logic [1:0]       r_state [WIDTH];
    logic [15:0]      r_hold  [WIDTH];
    logic [WIDTH-1:0] r_pend;
    logic [1:0]       r_ptype [WIDTH];
    logic [IDW-1:0]   r_rr;
    logic             r_ev_valid;
    logic [IDW-1:0]   r_ev_id;
    logic [1:0]       r_ev_type;
    logic             r_ev_drop;

    logic             w_tick;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [1:0]       w_state_nxt [WIDTH];
    logic [15:0]      w_hold_nxt  [WIDTH];
    logic [WIDTH-1:0] w_gen;
    logic [1:0]       w_gtype [WIDTH];
    logic             w_load;
    logic             w_found;
    logic [IDW-1:0]   w_win;
    logic [WIDTH-1:0] w_grant;
    int               w_k;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    assign w_tick = (r_pre == PRE_MAX);
    assign w_rise = lvl & ~r_lvl_q;
    assign w_fall = ~lvl & r_lvl_q;
    assign w_load = ~r_ev_valid | ev_ready;

    // Hold-timer prescaler and level history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre   <= '0;
            r_lvl_q <= '0;
        end else begin
            r_pre   <= w_tick ? '0 : (r_pre + PW'(1));
            r_lvl_q <= lvl;
        end
    end

    // Per-button event FSM; a release always wins over a same-cycle tick
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_hold_nxt[i]  = r_hold[i];
            w_gen[i]       = 1'b0;
            w_gtype[i]     = EV_PRESS;
            case (r_state[i])
                ST_IDLE: begin
                    if (w_rise[i]) begin
                        w_gen[i]       = 1'b1;
                        w_gtype[i]     = EV_PRESS;
                        w_hold_nxt[i]  = 16'd0;
                        w_state_nxt[i] = ST_HELD;
                    end else begin
                        w_state_nxt[i] = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (w_fall[i]) begin
                        w_gen[i]       = 1'b1;
                        w_gtype[i]     = EV_RELEASE;
                        w_state_nxt[i] = ST_IDLE;
                    end else if (w_tick) begin
                        if (sat_inc(r_hold[i]) == LONG_T) begin
                            w_gen[i]       = 1'b1;
                            w_gtype[i]     = EV_LONG;
                            w_hold_nxt[i]  = 16'd0;
                            w_state_nxt[i] = ST_LONG;
                        end else begin
                            w_hold_nxt[i]  = sat_inc(r_hold[i]);
                        end
                    end else begin
                        w_hold_nxt[i] = r_hold[i];
                    end
                end
                ST_LONG: begin
                    if (w_fall[i]) begin
                        w_gen[i]       = 1'b1;
                        w_gtype[i]     = EV_RELEASE;
                        w_state_nxt[i] = ST_IDLE;
                    end else begin
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
                        if (w_tick) begin
                            if (sat_inc(r_hold[i]) == REP_T) begin
                                w_gen[i]      = 1'b1;
                                w_gtype[i]    = EV_REPEAT;
                                w_hold_nxt[i] = 16'd0;
                            end else begin
                                w_hold_nxt[i] = sat_inc(r_hold[i]);
                            end
                        end else begin
                            w_hold_nxt[i] = r_hold[i];
                        end
`else
                        w_state_nxt[i] = ST_LONG;
`endif
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_IDLE;
                    w_hold_nxt[i]  = 16'd0;
                end
            endcase
        end
    end

    // Round-robin search for the first pending slot at or after r_rr
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_k     = 0;
        for (int j = 0; j < WIDTH; j++) begin
            w_k = int'(r_rr) + j;
            if (w_k >= WIDTH) begin
                w_k = w_k - WIDTH;
            end else begin
                w_k = w_k;
            end
            if (!w_found && r_pend[w_k]) begin
                w_found = 1'b1;
                w_win   = IDW'(w_k);
            end else begin
                w_found = w_found;
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            w_grant[i] = w_load & w_found & (w_win == IDW'(i));
        end
    end

    // Per-button FSM state and pending slots; a same-cycle grant frees the slot without a drop
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= ST_IDLE;
                r_hold[i]  <= 16'd0;
                r_ptype[i] <= 2'd0;
            end
            r_pend    <= '0;
            r_ev_drop <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_hold[i]  <= w_hold_nxt[i];
                r_ptype[i] <= w_gen[i] ? w_gtype[i] : r_ptype[i];
            end
            r_pend    <= w_gen | (r_pend & ~w_grant);
            r_ev_drop <= |(w_gen & r_pend & ~w_grant);
        end
    end

    // Output register: reloads whenever empty or the current event is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ev_valid <= 1'b0;
            r_ev_id    <= '0;
            r_ev_type  <= 2'd0;
            r_rr       <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_ev_valid <= 1'b1;
                r_ev_id    <= w_win;
                r_ev_type  <= r_ptype[w_win];
                r_rr       <= (w_win == IDW'(WIDTH - 1)) ? '0 : (w_win + IDW'(1));
            end else begin
                r_ev_valid <= 1'b0;
            end
        end else begin
            r_ev_valid <= r_ev_valid;
        end
    end

    assign ev_valid = r_ev_valid;
    assign ev_id    = r_ev_id;
    assign ev_type  = r_ev_type;
    assign ev_drop  = r_ev_drop;

endmodule

// File: tb/tb_button_event_sched.sv
// Scoreboard bench for button_event_sched (WIDTH=4, CDIV=4, LONG_TICKS=3, REPEAT_TICKS=2).
module tb_button_event_sched;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] ty;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] lvl;
    logic       ev_ready;
    logic       ev_valid;
    logic [1:0] ev_id;
    logic [1:0] ev_type;
    logic       ev_drop;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    button_event_sched #(
        .WIDTH(4), .CDIV(4), .LONG_TICKS(3), .REPEAT_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .lvl(lvl),
        .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_id(ev_id), .ev_type(ev_type), .ev_drop(ev_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_neg(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [1:0] ty);
        exp_t e;
        e.id = id;
        e.ty = ty;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ev_valid && ev_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got id=%0d type=%0d, required no event", ev_id, ev_type);
                end else begin
                    e = sb.pop_front();
                    if ({ev_id, ev_type} !== {e.id, e.ty}) begin
                        errors++;
                        $display("FAIL sb_event: got id=%0d type=%0d, required id=%0d type=%0d",
                                 ev_id, ev_type, e.id, e.ty);
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            cyc_neg(1);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d events outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        do begin
            cyc_neg(1);
            n++;
        end while (!ev_valid && n < bound);
        if (!ev_valid) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: ev_valid=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic do_reset();
        drive_pt();
        rst = 1'b1;
        lvl = 4'b0000;
        ev_ready = 1'b1;
        drive_pt();
        drive_pt();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        // Outputs during reset
        cyc_neg(2);
        checks++;
        if ({ev_valid, ev_id, ev_type, ev_drop} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b id=%0d t=%0d d=%0b, required all 0",
                     ev_valid, ev_id, ev_type, ev_drop);
        end
        rst = 1'b0;
        // Reset while an event sits unaccepted on the port
        drive_pt();
        ev_ready = 1'b0;
        lvl = 4'b0001;
        cyc_neg(2);
        checks++;
        if ({ev_valid, ev_id, ev_type} !== {1'b1, 2'd0, 2'd0}) begin
            errors++;
            $display("FAIL reset_pre_valid: got v=%0b id=%0d t=%0d, required v=1 id=0 t=0",
                     ev_valid, ev_id, ev_type);
        end
        drive_pt();
        rst = 1'b1;
        cyc_neg(1);
        checks++;
        if ({ev_valid, ev_id, ev_type, ev_drop} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_hs: got v=%0b id=%0d t=%0d d=%0b, required all 0",
                     ev_valid, ev_id, ev_type, ev_drop);
        end
        rst = 1'b0;
        ev_ready = 1'b1;
        push(2'd0, 2'd0);
        cyc_neg(1);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_latency1: got v=%0b, required v=0", ev_valid);
        end
        cyc_neg(1);
        checks++;
        if ({ev_valid, ev_id, ev_type} !== {1'b1, 2'd0, 2'd0}) begin
            errors++;
            $display("FAIL reset_repress: got v=%0b id=%0d t=%0d, required v=1 id=0 t=0",
                     ev_valid, ev_id, ev_type);
        end
        drive_pt();
        lvl = 4'b0000;
        push(2'd0, 2'd1);
        wait_drain(10);
        cyc_neg(3);
    endtask

    task automatic test_press_release();
        do_reset();
        lvl[1] = 1'b1;
        push(2'd1, 2'd0);
        cyc_neg(1);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL press_early: got v=%0b, required v=0", ev_valid);
        end
        cyc_neg(1);
        checks++;
        if ({ev_valid, ev_id, ev_type} !== {1'b1, 2'd1, 2'd0}) begin
            errors++;
            $display("FAIL press_out: got v=%0b id=%0d t=%0d, required v=1 id=1 t=0",
                     ev_valid, ev_id, ev_type);
        end
        cyc_neg(1);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL press_one_cycle: got v=%0b, required v=0", ev_valid);
        end
        drive_pt();
        lvl[1] = 1'b0;
        push(2'd1, 2'd1);
        cyc_neg(1);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_early: got v=%0b, required v=0", ev_valid);
        end
        cyc_neg(1);
        checks++;
        if ({ev_valid, ev_id, ev_type} !== {1'b1, 2'd1, 2'd1}) begin
            errors++;
            $display("FAIL release_out: got v=%0b id=%0d t=%0d, required v=1 id=1 t=1",
                     ev_valid, ev_id, ev_type);
        end
        wait_drain(5);
        cyc_neg(3);
    endtask

    task automatic test_long_press();
        int n;
        int quiet;
        do_reset();
        lvl[2] = 1'b1;
        push(2'd2, 2'd0);
        wait_valid(10, n);
        push(2'd2, 2'd2);
        wait_valid(30, n);
        checks++;
        if (n < 9 || n > 12 || ev_type !== 2'd2 || ev_id !== 2'd2) begin
            errors++;
            $display("FAIL long_event: got delay=%0d id=%0d t=%0d, required delay 9..12 id=2 t=2",
                     n, ev_id, ev_type);
        end
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
        for (int r = 0; r < 2; r++) begin
            push(2'd2, 2'd3);
            wait_valid(20, n);
            checks++;
            if (n != 8 || ev_type !== 2'd3 || ev_id !== 2'd2) begin
                errors++;
                $display("FAIL repeat_event: got delay=%0d id=%0d t=%0d, required delay 8 id=2 t=3",
                         n, ev_id, ev_type);
            end
        end
        drive_pt();
        lvl[2] = 1'b0;
        push(2'd2, 2'd1);
        wait_drain(10);
`else
        quiet = 0;
        for (int c = 0; c < 30; c++) begin
            cyc_neg(1);
            if (ev_valid) quiet++;
        end
        checks++;
        if (quiet != 0) begin
            errors++;
            $display("FAIL long_no_repeat: got %0d extra valid cycles, required 0", quiet);
        end
        drive_pt();
        lvl[2] = 1'b0;
        push(2'd2, 2'd1);
        wait_drain(10);
`endif
        quiet = 0;
        for (int c = 0; c < 20; c++) begin
            cyc_neg(1);
            if (ev_valid) quiet++;
        end
        checks++;
        if (quiet != 0) begin
            errors++;
            $display("FAIL after_release_quiet: got %0d valid cycles, required 0", quiet);
        end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_ids [3];
        exp_ids[0] = 2'd0;
        exp_ids[1] = 2'd2;
        exp_ids[2] = 2'd3;
        do_reset();
        lvl = 4'b1101;
        for (int i = 0; i < 3; i++) push(exp_ids[i], 2'd0);
        cyc_neg(1);
        for (int i = 0; i < 3; i++) begin
            cyc_neg(1);
            checks++;
            if ({ev_valid, ev_id, ev_type} !== {1'b1, exp_ids[i], 2'd0}) begin
                errors++;
                $display("FAIL arb_order%0d: got v=%0b id=%0d t=%0d, required v=1 id=%0d t=0",
                         i, ev_valid, ev_id, ev_type, exp_ids[i]);
            end
        end
        cyc_neg(1);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL arb_idle: got v=%0b, required v=0", ev_valid);
        end
        // Pointer back at 0: releases of 3, 2 and 0 must drain 0, 2, 3
        drive_pt();
        lvl = 4'b0000;
        for (int i = 0; i < 3; i++) push(exp_ids[i], 2'd1);
        wait_drain(10);
        cyc_neg(3);
    endtask

    task automatic test_back_to_back_drop();
        do_reset();
        ev_ready = 1'b0;
        lvl[3] = 1'b1;
        push(2'd3, 2'd0);
        cyc_neg(2);
        drive_pt();
        lvl[3] = 1'b0;
        cyc_neg(2);
        checks++;
        if ({ev_valid, ev_id, ev_type, ev_drop} !== {1'b1, 2'd3, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold: got v=%0b id=%0d t=%0d d=%0b, required v=1 id=3 t=0 d=0",
                     ev_valid, ev_id, ev_type, ev_drop);
        end
        drive_pt();
        lvl[3] = 1'b1;
        push(2'd3, 2'd0);
        cyc_neg(1);
        checks++;
        if (ev_drop !== 1'b1 || ev_id !== 2'd3 || ev_type !== 2'd0) begin
            errors++;
            $display("FAIL drop_pulse: got d=%0b id=%0d t=%0d, required d=1 id=3 t=0",
                     ev_drop, ev_id, ev_type);
        end
        cyc_neg(1);
        checks++;
        if (ev_drop !== 1'b0) begin
            errors++;
            $display("FAIL drop_width: got d=%0b, required d=0", ev_drop);
        end
        drive_pt();
        ev_ready = 1'b1;
        wait_drain(10);
        drive_pt();
        lvl[3] = 1'b0;
        push(2'd3, 2'd1);
        wait_drain(10);
        cyc_neg(3);
    endtask

    initial begin
        rst = 1'b1;
        lvl = 4'b0000;
        ev_ready = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_press_release();
        test_long_press();
        test_arbitration();
        test_back_to_back_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event_sched.md
Name: button_event_sched

Overview:
- Sits downstream of the per-button debounce stage and converts debounced levels into discrete events: press, release, long-press and (optionally) auto-repeat.
- Holds one pending event slot per button.
- A round-robin arbiter serialises the pending events onto a single valid/ready event port.
- The port feeds the UI controller or an event FIFO.

Parameters:
- WIDTH, 4: number of buttons; must be at least 2.
- CDIV, 50_000: clk cycles per hold-timer tick (1 ms at 50 MHz).
- LONG_TICKS, 500: ticks of continuous hold before the long-press event.
- REPEAT_TICKS, 100: ticks between repeat events after a long press (only with AUTOREPEAT_EN).
- IDW, $clog2(WIDTH): local parameter; width of the event id.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- lvl  in  WIDTH  debounced button levels, synchronous to clk; 1 = pressed.
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts the event.
- ev_id  out  IDW  button index of the event.
- ev_type  out  2  0 = press, 1 = release, 2 = long, 3 = repeat.
- ev_drop  out  1  one-cycle pulse when a pending event is overwritten.

Behaviour:
- Reset (synchronous, active-high, clk edge with rst=1):
  - ev_valid, ev_id, ev_type and ev_drop all go to 0.
  - The prescaler, hold counters, lvl_q, pending bits, per-button states and the RR pointer all clear.
  - A button held through reset produces a press event on the first cycle after rst deasserts, because lvl_q resets to 0.
- Prescaler: free-running 0..CDIV-1. tick = 1 for one cycle when count == CDIV-1, then the count wraps to 0.
- Edge detect: lvl_q <= lvl every cycle.
  - rise = lvl & ~lvl_q
  - fall = ~lvl & lvl_q
- Per-button FSM:
  - IDLE:
    - On rise: generate press, hold_cnt <= 0, go to HELD.
  - HELD:
    - On fall: generate release, go to IDLE.
    - Else on tick: hold_cnt++.
    - When the incremented value == LONG_TICKS: generate long, hold_cnt <= 0, go to LONG.
  - LONG:
    - On fall: generate release, go to IDLE.
    - Otherwise behaviour is per AUTOREPEAT_EN (see Optional Feature).
  - fall takes priority over tick in the same cycle.
  - hold_cnt is 16 bits and saturates; it never wraps.
- Pending slot:
  - A generated event sets pend[i] and loads ptype[i] on the same clk edge that lvl_q updates.
  - Event already pending and not granted that cycle: the new event overwrites it and ev_drop pulses for 1 cycle.
  - Same-cycle grant and new event for the same button: the old event goes out, the new one is stored, and there is no drop.
- Output register:
  - Loads when ev_valid==0 or (ev_valid & ev_ready).
  - Winner is the first pending index at or after rr_ptr, searching upward with wrap.
  - On load: ev_valid <= 1, ev_id/ev_type <= winner, pend[winner] cleared, rr_ptr <= winner+1 (wraps mod WIDTH).
  - No pending events: ev_valid <= 0 on the next load.
- Handshake:
  - While ev_valid & ~ev_ready, ev_id and ev_type are held stable.
  - ev_valid never deasserts without a handshake.
  - Back-to-back transfers run at one event per cycle.
- Latency: lvl change visible before clk edge k gives pend set at edge k and ev_valid high after edge k+1, i.e. 2 cycles, when the output register is free.
- Boundaries:
  - Simultaneous rise on several buttons: all are pended in the same cycle and drained one per accepted handshake in RR order.
  - rst asserted mid-handshake: the event is discarded.

Optional Feature:
- Macro: BUTTON_EVENT_AUTOREPEAT_EN.
- Defined:
  - In LONG, each tick increments hold_cnt.
  - When the incremented value == REPEAT_TICKS: generate repeat and set hold_cnt <= 0.
  - Repeat events repeat until release.
- Undefined:
  - LONG is inert until fall.
  - ev_type 3 is never produced.
  - The REPEAT_TICKS logic is not synthesised.

Test Plan (WIDTH=4, CDIV=4, LONG_TICKS=3, REPEAT_TICKS=2, ev_ready=1 unless stated):
- Single press, then release:
  - lvl[1] rises before edge 10 -> ev_valid=1, id=1, type=0 for exactly the cycle after edge 11.
  - lvl[1] falls at edge 20 -> id=1, type=1 after edge 21.
- Long press: hold lvl[2] -> one type=2 event, id=2, after the 3rd tick following the press (9..12 clk after the press event); no further events without AUTOREPEAT_EN.
- Auto-repeat, with BUTTON_EVENT_AUTOREPEAT_EN: continue the hold -> type=3, id=2, every 8 clk; release -> type=1, and repeats stop.
- Arbitration: lvl[0], lvl[2] and lvl[3] rise in the same cycle -> ids 0, 2, 3 in three consecutive valid cycles, each type=0; then rr_ptr=0.
- Backpressure and drop:
  - ev_ready=0, press then release btn 3 -> ev_valid holds id=3, type=0 stable; release is pended.
  - Press btn 3 again -> ev_drop=1 for 1 cycle.
  - ev_ready=1 -> events type=0, then type=0 (the release is lost).
- Reset: rst=1 for 1 cycle while lvl[0] is held and ev_valid=1 -> all outputs 0 after that edge; after rst=0 a fresh press event for id=0 appears after 2 cycles.
